// File: rtl/sni_uart_pkg.sv
// Shared types and constants for the SNI serial transceiver.
package sni_uart_pkg;

    localparam int DATA_BITS     = 8;
    localparam int FRAME_ERR_BIT = 8;
    localparam int OVERRUN_BIT   = 9;

    // Extra cycles TX spends in WAIT before it first looks at the
    // synchronised cts_n. This keeps the launch latency equal to the
    // synchroniser depth, whether cts_n was already low or not.
    localparam int TX_WAIT_DWELL = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK,
        RX_HAND
    } rxState_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_WAIT,
        TX_START,
        TX_DATA,
        TX_STOP
    } txState_t;

    // Packs a received byte and the sticky status flags into the engine word.
    function automatic logic [15:0] buildStatus(input logic [7:0] data,
                                                input logic       frameErr,
                                                input logic       overrun);
        logic [15:0] status;
        status                = '0;
        status[7:0]           = data;
        status[FRAME_ERR_BIT] = frameErr;
        status[OVERRUN_BIT]   = overrun;
        return status;
    endfunction

endpackage

// File: rtl/sni_uart_if.sv
// Engine-side port bundle of the SNI transceiver: receive-buffer write
// port, transmit request and the two interrupt-style strobes.
interface sni_uart_if;
    import sni_uart_pkg::*;

    logic        rbf;
    logic        rxint;
    logic [15:0] rdata_m;
    logic        tdata_i;
    logic [15:0] tdata_m;
    logic        txint;

    // The command engine drives requests and observes the strobes.
    modport master (
        output rbf,
        output tdata_i,
        output tdata_m,
        input  rxint,
        input  rdata_m,
        input  txint
    );

    // The transceiver consumes requests and drives the strobes.
    modport slave (
        input  rbf,
        input  tdata_i,
        input  tdata_m,
        output rxint,
        output rdata_m,
        output txint
    );

endinterface

// File: rtl/sni_uart_rx.sv
// 8N1 receiver: input synchroniser, mid-bit sampling FSM, sticky
// frame-error/overrun flags and the one-cycle hand-over to the engine.
module sni_uart_rx
    import sni_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 186
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_rxd,
    input  logic        i_rbf,
    output logic        o_rxint,
    output logic [15:0] o_rdataM
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       r_rxSync;
    rxState_t         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic             r_frameErr;
    logic             r_overrun;
    logic [15:0]      r_rdata;

    rxState_t         w_stateNext;
    logic [CNT_W-1:0] w_cntNext;
    logic [2:0]       w_bitIdxNext;
    logic [7:0]       w_shiftNext;
    logic             w_frameErrNext;
    logic             w_overrunNext;
    logic [15:0]      w_rdataNext;
    logic             w_rxd;
    logic             w_midBit;

    assign w_rxd    = r_rxSync[1];
    assign w_midBit = (r_cnt == '0);

    // Two-flop synchroniser for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rxSync <= 2'b11;
        end else begin
            r_rxSync <= {r_rxSync[0], i_rxd};
        end
    end

    // State and datapath registers for the receive FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RX_IDLE;
            r_cnt      <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_bitIdx   <= w_bitIdxNext;
            r_shift    <= w_shiftNext;
            r_frameErr <= w_frameErrNext;
            r_overrun  <= w_overrunNext;
            r_rdata    <= w_rdataNext;
        end
    end

    // Next-state logic: the bit counter hits zero at the middle of each bit,
    // which is where the line is sampled. The engine word is loaded on entry
    // to HAND so it is already valid while rxint is high.
    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = r_cnt;
        w_bitIdxNext   = r_bitIdx;
        w_shiftNext    = r_shift;
        w_frameErrNext = r_frameErr;
        w_overrunNext  = r_overrun;
        w_rdataNext    = r_rdata;

        case (r_state)
            RX_IDLE: begin
                if (!w_rxd) begin
                    w_stateNext = RX_START;
                    w_cntNext   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (w_midBit) begin
                    if (w_rxd) begin
                        w_stateNext = RX_IDLE;
                    end else begin
                        w_stateNext  = RX_DATA;
                        w_cntNext    = FULL_LOAD;
                        w_bitIdxNext = '0;
                    end
                end else begin
                    w_cntNext = r_cnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (w_midBit) begin
                    w_shiftNext = {w_rxd, r_shift[7:1]};
                    w_cntNext   = FULL_LOAD;
                    if (r_bitIdx == 3'(DATA_BITS - 1)) begin
                        w_stateNext = RX_STOP;
                    end else begin
                        w_bitIdxNext = r_bitIdx + 1'b1;
                    end
                end else begin
                    w_cntNext = r_cnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (w_midBit) begin
                    if (!w_rxd) begin
                        w_frameErrNext = 1'b1;
                        w_stateNext    = RX_BREAK;
                    end else if (i_rbf) begin
                        w_overrunNext = 1'b1;
                        w_stateNext   = RX_IDLE;
                    end else begin
                        w_rdataNext = buildStatus(r_shift, r_frameErr, r_overrun);
                        w_stateNext = RX_HAND;
                    end
                end else begin
                    w_cntNext = r_cnt - 1'b1;
                end
            end
            RX_BREAK: begin
                if (w_rxd) begin
                    w_stateNext = RX_IDLE;
                end
            end
            RX_HAND: begin
                w_stateNext = RX_IDLE;
            end
            default: begin
                w_stateNext = RX_IDLE;
            end
        endcase
    end

    assign o_rxint  = (r_state == RX_HAND);
    assign o_rdataM = r_rdata;

endmodule

// File: rtl/sni_uart.sv
// SNI serial transceiver top: RTS/CTS flow control, the receiver
// sub-module and the inline 8N1 transmitter.
module sni_uart
    import sni_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 186
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     rxd,
    output logic     txd,
    input  logic     cts_n,
    output logic     rts_n,
    sni_uart_if.slave eng
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(TX_WAIT_DWELL);

    logic [1:0]       r_ctsSync;
    logic             r_rts;
    txState_t         r_txState;
    logic [CNT_W-1:0] r_txCnt;
    logic [2:0]       r_txBitIdx;
    logic [7:0]       r_txShift;
    logic             r_txd;
    logic             r_txint;

    txState_t         w_txStateNext;
    logic [CNT_W-1:0] w_txCntNext;
    logic [2:0]       w_txBitIdxNext;
    logic [7:0]       w_txShiftNext;
    logic             w_txdNext;
    logic             w_txintNext;
    logic             w_cts;
    logic             w_txCntZero;
    logic             w_unusedTdataHi;

    assign w_cts       = r_ctsSync[1];
    assign w_txCntZero = (r_txCnt == '0);

    // The upper byte of the transmit word carries nothing for the line.
    assign w_unusedTdataHi = &{1'b0, eng.tdata_m[15:8]};

    sni_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_rxd    (rxd),
        .i_rbf    (eng.rbf),
        .o_rxint  (eng.rxint),
        .o_rdataM (eng.rdata_m)
    );

    // Synchronise cts_n and register the buffer-full flag as rts_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctsSync <= 2'b11;
            r_rts     <= 1'b1;
        end else begin
            r_ctsSync <= {r_ctsSync[0], cts_n};
            r_rts     <= eng.rbf;
        end
    end

    // State and datapath registers for the transmit FSM; txd idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_txState  <= TX_IDLE;
            r_txCnt    <= '0;
            r_txBitIdx <= '0;
            r_txShift  <= '0;
            r_txd      <= 1'b1;
            r_txint    <= 1'b0;
        end else begin
            r_txState  <= w_txStateNext;
            r_txCnt    <= w_txCntNext;
            r_txBitIdx <= w_txBitIdxNext;
            r_txShift  <= w_txShiftNext;
            r_txd      <= w_txdNext;
            r_txint    <= w_txintNext;
        end
    end

    // Next-state logic: txd is registered from the next-state decision so
    // each line level lasts exactly CLKS_PER_BIT cycles. cts_n is only
    // consulted in WAIT; a frame in flight always runs to its stop bit.
    always_comb begin
        w_txStateNext  = r_txState;
        w_txCntNext    = r_txCnt;
        w_txBitIdxNext = r_txBitIdx;
        w_txShiftNext  = r_txShift;
        w_txdNext      = r_txd;
        w_txintNext    = r_txint;

        case (r_txState)
            TX_IDLE: begin
                w_txdNext = 1'b1;
                if (eng.tdata_i) begin
                    w_txShiftNext = eng.tdata_m[7:0];
                    w_txintNext   = 1'b1;
                    w_txCntNext   = DWELL_LOAD;
                    w_txStateNext = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!w_txCntZero) begin
                    w_txCntNext = r_txCnt - 1'b1;
                end else if (!w_cts) begin
                    w_txdNext     = 1'b0;
                    w_txCntNext   = FULL_LOAD;
                    w_txStateNext = TX_START;
                end
            end
            TX_START: begin
                if (w_txCntZero) begin
                    w_txdNext      = r_txShift[0];
                    w_txShiftNext  = {1'b0, r_txShift[7:1]};
                    w_txBitIdxNext = '0;
                    w_txCntNext    = FULL_LOAD;
                    w_txStateNext  = TX_DATA;
                end else begin
                    w_txCntNext = r_txCnt - 1'b1;
                end
            end
            TX_DATA: begin
                if (w_txCntZero) begin
                    w_txCntNext = FULL_LOAD;
                    if (r_txBitIdx == 3'(DATA_BITS - 1)) begin
                        w_txdNext     = 1'b1;
                        w_txStateNext = TX_STOP;
                    end else begin
                        w_txdNext      = r_txShift[0];
                        w_txShiftNext  = {1'b0, r_txShift[7:1]};
                        w_txBitIdxNext = r_txBitIdx + 1'b1;
                    end
                end else begin
                    w_txCntNext = r_txCnt - 1'b1;
                end
            end
            TX_STOP: begin
                if (w_txCntZero) begin
                    w_txintNext   = 1'b0;
                    w_txStateNext = TX_IDLE;
                end else begin
                    w_txCntNext = r_txCnt - 1'b1;
                end
            end
            default: begin
                w_txdNext     = 1'b1;
                w_txintNext   = 1'b0;
                w_txStateNext = TX_IDLE;
            end
        endcase
    end

    assign txd       = r_txd;
    assign rts_n     = r_rts;
    assign eng.txint = r_txint;

endmodule
